// File: rtl/wb_regfile_if.sv
`default_nettype none
// ============================================================================
//  Module   : wb_regfile_if
//  Purpose  : Bundles the MEM/WB latch outputs, the decode read ports and the
//             writeback status outputs of the writeback / register-file stage.
//  Modports : master - the pipeline side (drives latch fields and read
//                      indices, observes read data and status)
//             slave  - the wb_regfile stage itself
//  Signals  : wb_valid, npc_o, port_out_o, dmemload_o, zeroExt_o, rd_o,
//             regWr_o, halt_o, rdSel_o, rsel1, rsel2      (master -> slave)
//             rdat1, rdat2, wb_data, wb_rd, wb_wen, halted,
//             retire_cnt                                  (slave -> master)
//  Revision : 1.0  initial release
// ============================================================================
interface wb_regfile_if #(
    parameter int CNT_W = 32
);
    // MEM/WB latch contents
    logic             wb_valid;
    logic [31:0]      npc_o;
    logic [31:0]      port_out_o;
    logic [31:0]      dmemload_o;
    logic [31:0]      zeroExt_o;
    logic [4:0]       rd_o;
    logic             regWr_o;
    logic             halt_o;
    logic [2:0]       rdSel_o;

    // Decode-stage read indices and data
    logic [4:0]       rsel1;
    logic [4:0]       rsel2;
    logic [31:0]      rdat1;
    logic [31:0]      rdat2;

    // Writeback view for the forwarding unit and system status
    logic [31:0]      wb_data;
    logic [4:0]       wb_rd;
    logic             wb_wen;
    logic             halted;
    logic [CNT_W-1:0] retire_cnt;

    modport master (
        output wb_valid, npc_o, port_out_o, dmemload_o, zeroExt_o,
               rd_o, regWr_o, halt_o, rdSel_o, rsel1, rsel2,
        input  rdat1, rdat2, wb_data, wb_rd, wb_wen, halted, retire_cnt
    );

    modport slave (
        input  wb_valid, npc_o, port_out_o, dmemload_o, zeroExt_o,
               rd_o, regWr_o, halt_o, rdSel_o, rsel1, rsel2,
        output rdat1, rdat2, wb_data, wb_rd, wb_wen, halted, retire_cnt
    );
endinterface
`default_nettype wire

// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : wb_regfile
//  Purpose  : Writeback stage and architectural register file. Selects the
//             writeback word from the MEM/WB latch, commits it to the
//             register file, serves two asynchronous decode read ports,
//             and keeps the sticky halt flag and retired-instruction count.
//  Ports    : CLK  - clock, rising edge
//             RST  - synchronous active-high reset
//             bus  - wb_regfile_if.slave (latch fields, read ports, status)
//  Params   : NREGS - number of architectural registers (x0 reads as zero)
//             CNT_W - width of the retired-instruction counter
//  Options  : WB_BYPASS_EN - when defined, a read of the register being
//             written in the same cycle returns the new word (write-through);
//             when undefined the read returns the stored (pre-write) value.
//  Revision : 1.0  initial release
// ============================================================================
module wb_regfile #(
    parameter int NREGS = 32,
    parameter int CNT_W = 32
) (
    input  logic         CLK,
    input  logic         RST,
    wb_regfile_if.slave  bus
);

    // Writeback source encodings
    localparam logic [2:0] c_SEL_ALU  = 3'd0;
    localparam logic [2:0] c_SEL_LOAD = 3'd1;
    localparam logic [2:0] c_SEL_LINK = 3'd2;
    localparam logic [2:0] c_SEL_IMM  = 3'd3;

    localparam int         c_NPORTS   = 2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]      r_regs [NREGS];
    logic             r_halted;
    logic [CNT_W-1:0] r_retireCnt;

    // ------------------------------------------------------------------
    // Combinational writeback path
    // ------------------------------------------------------------------
    logic [31:0]      w_wbData;
    logic             w_rdInRange;
    logic             w_wen;
    logic             w_retire;

    // Reserved select codes fall back to the ALU result so a corrupted
    // select never produces an undefined writeback word.
    always_comb begin
        w_wbData = bus.port_out_o;
        case (bus.rdSel_o)
            c_SEL_ALU:  w_wbData = bus.port_out_o;
            c_SEL_LOAD: w_wbData = bus.dmemload_o;
            c_SEL_LINK: w_wbData = bus.npc_o;
            c_SEL_IMM:  w_wbData = bus.zeroExt_o;
            default:    w_wbData = bus.port_out_o;
        endcase
    end

    // Destinations beyond the implemented register count are dropped so a
    // reduced-size file never aliases onto a real register.
    assign w_rdInRange = (32'(bus.rd_o) < 32'(NREGS));

    // The HALT instruction itself never writes, and nothing writes once
    // halted; x0 is never a legal destination.
    assign w_wen = bus.wb_valid & bus.regWr_o & ~bus.halt_o & ~r_halted
                 & (bus.rd_o != 5'd0) & w_rdInRange;

    // Every real instruction retires (including HALT) until halted.
    assign w_retire = bus.wb_valid & ~r_halted;

    // ------------------------------------------------------------------
    // Sequential state: register file, halt flag, retire counter.
    // Reset has priority and discards any commit presented in that cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_halted    <= 1'b0;
            r_retireCnt <= '0;
        end else begin
            if (w_wen) begin
                r_regs[bus.rd_o] <= w_wbData;
            end
            if (w_retire) begin
                // Natural wrap at the counter width.
                r_retireCnt <= r_retireCnt + 1'b1;
                if (bus.halt_o) begin
                    r_halted <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Asynchronous read ports
    // ------------------------------------------------------------------
    logic [4:0]  w_rsel [c_NPORTS];
    logic [31:0] w_rdat [c_NPORTS];

    assign w_rsel[0] = bus.rsel1;
    assign w_rsel[1] = bus.rsel2;

    always_comb begin
        for (int p = 0; p < c_NPORTS; p++) begin
            w_rdat[p] = '0;
            // x0 and unimplemented indices read as zero.
            if ((w_rsel[p] != 5'd0) && (32'(w_rsel[p]) < 32'(NREGS))) begin
                w_rdat[p] = r_regs[w_rsel[p]];
`ifdef WB_BYPASS_EN
                // Write-through: the word being committed this cycle wins
                // over the stored copy.
                if (w_wen && (w_rsel[p] == bus.rd_o)) begin
                    w_rdat[p] = w_wbData;
                end
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // Output drive
    // ------------------------------------------------------------------
    assign bus.rdat1      = w_rdat[0];
    assign bus.rdat2      = w_rdat[1];
    assign bus.wb_data    = w_wbData;
    assign bus.wb_rd      = bus.rd_o;
    assign bus.wb_wen     = w_wen;
    assign bus.halted     = r_halted;
    assign bus.retire_cnt = r_retireCnt;

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_regfile
//  Purpose  : Self-checking bench for wb_regfile. A driver applies directed
//             and random MEM/WB traffic, predicts every output from an
//             array-based architectural model and queues the predictions;
//             a monitor compares them against the DUT on the falling edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wb_regfile;

    logic CLK = 1'b0;
    logic RST;

    always #5 CLK = ~CLK;

    wb_regfile_if #(.CNT_W(32)) bus ();

    wb_regfile #(
        .NREGS (32),
        .CNT_W (32)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        int          kind;
        logic [31:0] exp;
    } exp_t;

    exp_t sbq[$];
    int   nCompared = 0;
    int   nMismatch = 0;
    bit   checkOn   = 1'b0;

    // Architectural model
    logic [31:0] mRegs [32];
    bit          mHalted;
    logic [31:0] mCnt;

    function automatic string kindName(input int k);
        case (k)
            0: return "rdat1";
            1: return "rdat2";
            2: return "wb_data";
            3: return "wb_rd";
            4: return "wb_wen";
            5: return "halted";
            default: return "retire_cnt";
        endcase
    endfunction

    function automatic logic [31:0] actualOf(input int k);
        case (k)
            0: return bus.rdat1;
            1: return bus.rdat2;
            2: return bus.wb_data;
            3: return {27'd0, bus.wb_rd};
            4: return {31'd0, bus.wb_wen};
            5: return {31'd0, bus.halted};
            default: return bus.retire_cnt;
        endcase
    endfunction

    // Monitor: all outputs are steady at the falling edge.
    initial begin
        forever begin
            @(negedge CLK);
            while (sbq.size() > 0) begin
                exp_t        e;
                logic [31:0] act;
                e   = sbq.pop_front();
                act = actualOf(e.kind);
                nCompared++;
                if (act !== e.exp) begin
                    nMismatch++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h at %0t",
                             kindName(e.kind), act, e.exp, $time);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Model helpers
    // ------------------------------------------------------------------
    function automatic logic [31:0] expRead(input logic [4:0] rs, input bit wen,
                                            input logic [4:0] rd,
                                            input logic [31:0] wbd);
        if (rs == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
        if (wen && rs == rd) return wbd;
`endif
        return mRegs[rs];
    endfunction

    task automatic push(input int k, input logic [31:0] v);
        exp_t e;
        e.kind = k;
        e.exp  = v;
        sbq.push_back(e);
    endtask

    // One clock cycle: drive, predict, queue, advance model, step clock.
    task automatic step(input bit rst, input bit valid, input bit regWr,
                        input bit halt, input logic [4:0] rd,
                        input logic [2:0] sel, input logic [31:0] npc,
                        input logic [31:0] pout, input logic [31:0] load,
                        input logic [31:0] zext, input logic [4:0] rs1,
                        input logic [4:0] rs2);
        logic [31:0] wbd;
        bit          wen;
        RST            = rst;
        bus.wb_valid   = valid;
        bus.regWr_o    = regWr;
        bus.halt_o     = halt;
        bus.rd_o       = rd;
        bus.rdSel_o    = sel;
        bus.npc_o      = npc;
        bus.port_out_o = pout;
        bus.dmemload_o = load;
        bus.zeroExt_o  = zext;
        bus.rsel1      = rs1;
        bus.rsel2      = rs2;

        case (sel)
            3'd1:    wbd = load;
            3'd2:    wbd = npc;
            3'd3:    wbd = zext;
            default: wbd = pout;
        endcase
        wen = valid && regWr && !halt && !mHalted && (rd != 5'd0);

        if (checkOn) begin
            push(0, expRead(rs1, wen, rd, wbd));
            push(1, expRead(rs2, wen, rd, wbd));
            push(2, wbd);
            push(3, {27'd0, rd});
            push(4, {31'd0, wen});
            push(5, {31'd0, mHalted});
            push(6, mCnt);
        end

        if (rst) begin
            foreach (mRegs[i]) mRegs[i] = 32'd0;
            mHalted = 1'b0;
            mCnt    = 32'd0;
        end else begin
            if (wen) mRegs[rd] = wbd;
            if (valid && !mHalted) begin
                mCnt = mCnt + 32'd1;
                if (halt) mHalted = 1'b1;
            end
        end

        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input logic [4:0] rs1, input logic [4:0] rs2);
        step(1'b0, 1'b0, 1'b0, 1'b0, 5'($urandom), 3'($urandom), $urandom,
             $urandom, $urandom, $urandom, rs1, rs2);
    endtask

    task automatic wr(input logic [4:0] rd, input logic [2:0] sel,
                      input logic [31:0] npc, input logic [31:0] pout,
                      input logic [31:0] load, input logic [31:0] zext,
                      input logic [4:0] rs1, input logic [4:0] rs2);
        step(1'b0, 1'b1, 1'b1, 1'b0, rd, sel, npc, pout, load, zext, rs1, rs2);
    endtask

    task automatic randomCycle(input int haltOdds, input int rstOdds);
        bit         v, w, h, r;
        logic [4:0] rd, rs1, rs2;
        v   = ($urandom_range(3, 0) != 0);
        w   = ($urandom_range(3, 0) != 0);
        h   = (haltOdds != 0) && ($urandom_range(haltOdds - 1, 0) == 0);
        r   = (rstOdds  != 0) && ($urandom_range(rstOdds  - 1, 0) == 0);
        rd  = 5'($urandom);
        // Bias reads toward the destination to exercise same-cycle hazards.
        rs1 = ($urandom_range(3, 0) == 0) ? rd : 5'($urandom);
        rs2 = ($urandom_range(3, 0) == 0) ? rd : 5'($urandom);
        step(r, v, w, h, rd, 3'($urandom), $urandom, $urandom, $urandom,
             $urandom, rs1, rs2);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        RST            = 1'b1;
        bus.wb_valid   = 1'b0;
        bus.regWr_o    = 1'b0;
        bus.halt_o     = 1'b0;
        bus.rd_o       = '0;
        bus.rdSel_o    = '0;
        bus.npc_o      = '0;
        bus.port_out_o = '0;
        bus.dmemload_o = '0;
        bus.zeroExt_o  = '0;
        bus.rsel1      = '0;
        bus.rsel2      = '0;
        foreach (mRegs[i]) mRegs[i] = 32'd0;
        mHalted = 1'b0;
        mCnt    = 32'd0;
        @(posedge CLK);
        #1;

        // Reset for two cycles; state is unknown until it completes.
        step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 0, 0, 0, 0, 5'd0, 5'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 0, 0, 0, 0, 5'd0, 5'd0);
        checkOn = 1'b1;

        // Every register reads zero after reset.
        for (int i = 0; i < 32; i++) idle(5'(i), 5'(31 - i));

        // Simple ALU writeback.
        wr(5'd5, 3'd0, $urandom, 32'h1234, $urandom, $urandom, 5'd0, 5'd0);
        idle(5'd5, 5'd0);

        // Writeback source sweep on x7.
        wr(5'd7, 3'd2, 32'h40, $urandom, $urandom, $urandom, 5'd7, 5'd0);
        idle(5'd7, 5'd7);
        wr(5'd7, 3'd1, $urandom, $urandom, 32'hDEAD, $urandom, 5'd0, 5'd7);
        idle(5'd7, 5'd7);
        wr(5'd7, 3'd3, $urandom, $urandom, $urandom, 32'hABC00000, 5'd7, 5'd0);
        idle(5'd7, 5'd7);
        wr(5'd7, 3'd6, $urandom, 32'h9, $urandom, $urandom, 5'd0, 5'd0);
        idle(5'd7, 5'd7);

        // x0 write is dropped but still retires.
        wr(5'd0, 3'd0, $urandom, 32'hFFFFFFFF, $urandom, $urandom, 5'd0, 5'd0);
        idle(5'd0, 5'd0);

        // Same-cycle read of the register being written.
        wr(5'd3, 3'd0, $urandom, 32'h11, $urandom, $urandom, 5'd0, 5'd0);
        wr(5'd3, 3'd0, $urandom, 32'h55, $urandom, $urandom, 5'd0, 5'd3);
        idle(5'd3, 5'd3);

        // Random traffic without halts.
        for (int i = 0; i < 400; i++) randomCycle(0, 0);

        // HALT with regWr set, then a write that must be ignored.
        step(1'b0, 1'b1, 1'b1, 1'b1, 5'd9, 3'd0, $urandom, 32'hCAFE, $urandom,
             $urandom, 5'd9, 5'd10);
        wr(5'd10, 3'd0, $urandom, 32'h77, $urandom, $urandom, 5'd9, 5'd10);
        idle(5'd9, 5'd10);
        for (int i = 0; i < 20; i++) randomCycle(4, 0);

        // Reset clears halt; a write presented with reset is discarded.
        step(1'b1, 1'b1, 1'b1, 1'b0, 5'd4, 3'd0, $urandom, 32'hBEEF, $urandom,
             $urandom, 5'd4, 5'd9);
        idle(5'd4, 5'd9);

        // Random traffic with occasional halts and resets.
        for (int i = 0; i < 400; i++) randomCycle(60, 80);

        idle(5'd1, 5'd2);
        @(negedge CLK);
        @(negedge CLK);
        if (sbq.size() != 0) begin
            nCompared++;
            nMismatch++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0",
                     sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 nCompared, nMismatch);
        $finish;
    end

endmodule
`default_nettype wire
